// File: rtl/tpu_host_feeder_pkg.sv
// Shared types and constants for the TPU host feeder.
// State encoding, image size and class-index width.
package tpu_host_feeder_pkg;

  localparam int IMG_BITS = 1024;
  localparam int NUM_W    = 4;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    TRST = 2'd1,
    RUN  = 2'd2,
    CLR  = 2'd3
  } state_t;

endpackage

// File: rtl/tpu_host_feeder.sv
// Host-side initiator: assembles a 32x32 binary frame from bytes,
// runs the inference controller and latches its class result.
module tpu_host_feeder
  import tpu_host_feeder_pkg::*;
#(
  parameter int IMG_BYTES      = 128,
  parameter int RST_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                clk,
  input  logic                iRst_n,
  input  logic                pix_valid,
  input  logic [7:0]          pix_data,
  output logic                pix_ready,
  input  logic                frame_abort,
  input  logic                tpu_done,
  input  logic [NUM_W-1:0]    tpu_num,
  output logic                tpu_ena,
  output logic                tpu_rst_n,
  output logic [IMG_BITS-1:0] image,
  output logic [NUM_W-1:0]    result,
  output logic                result_valid,
  output logic                busy,
  output logic                timeout_err
);

  localparam int CW = $clog2(IMG_BYTES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int RW = $clog2(RST_CYCLES) + 1;

  localparam logic [CW-1:0] LAST_B = CW'(IMG_BYTES - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] LAST_R = RW'(RST_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    byte_q, byte_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic             rdy_d, ena_d, trn_d;
  logic             rv_d, busy_d, terr_d;
  logic [NUM_W-1:0] res_d;
  logic             wr_en;

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state_q      <= LOAD;
      byte_q       <= '0;
      tmr_q        <= '0;
      rcnt_q       <= '0;
      image        <= '0;
      pix_ready    <= 1'b1;
      tpu_ena      <= 1'b0;
      tpu_rst_n    <= 1'b1;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      tmr_q        <= tmr_d;
      rcnt_q       <= rcnt_d;
      pix_ready    <= rdy_d;
      tpu_ena      <= ena_d;
      tpu_rst_n    <= trn_d;
      result       <= res_d;
      result_valid <= rv_d;
      busy         <= busy_d;
      timeout_err  <= terr_d;
      if (wr_en)
        image[{byte_q, 3'b000} +: 8] <= pix_data;
    end
  end

  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    tmr_d   = tmr_q;
    rcnt_d  = rcnt_q;
    rdy_d   = pix_ready;
    ena_d   = tpu_ena;
    trn_d   = tpu_rst_n;
    res_d   = result;
    rv_d    = 1'b0;
    busy_d  = busy;
    terr_d  = timeout_err;
    wr_en   = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (frame_abort) begin
          byte_d = '0;
        end else if (pix_valid && pix_ready) begin
          wr_en = 1'b1;
          if (byte_q == LAST_B) begin
            byte_d  = '0;
            rcnt_d  = '0;
            state_d = TRST;
            rdy_d   = 1'b0;
            busy_d  = 1'b1;
            ena_d   = 1'b1;
            trn_d   = 1'b0;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      TRST: begin
        if (frame_abort) begin
          state_d = CLR;
          ena_d   = 1'b0;
          trn_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (rcnt_q == LAST_R) begin
          state_d = RUN;
          trn_d   = 1'b1;
          tmr_d   = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RUN: begin
        tmr_d = tmr_q + 1'b1;
        // abort wins over a done or timeout landing in the same cycle
        if (frame_abort || tpu_done || tmr_q == LAST_T) begin
          state_d = CLR;
          ena_d   = 1'b0;
          busy_d  = 1'b0;
        end
        if (frame_abort) begin
          terr_d = timeout_err;
        end else if (tpu_done) begin
          res_d  = tpu_num;
          rv_d   = 1'b1;
          terr_d = 1'b0;
        end else if (tmr_q == LAST_T) begin
          terr_d = 1'b1;
        end
      end
      CLR: begin
        state_d = LOAD;
        rdy_d   = 1'b1;
      end
      default: state_d = LOAD;
    endcase
  end

endmodule

// File: tb/tb_tpu_host_feeder.sv
// Bench: two feeders (default and short timeout) share one stimulus
// stream; outcomes are predicted from done/abort/timeout arithmetic.
module tb_tpu_host_feeder;
  import tpu_host_feeder_pkg::*;

  localparam int NB = 128;
  localparam int TA = 1048576;
  localparam int TB = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          iRst_n, pix_valid, frame_abort, tpu_done;
  logic [7:0]    pix_data;
  logic [3:0]    tpu_num;

  logic          a_rdy, a_ena, a_trn, a_rv, a_busy, a_terr;
  logic [3:0]    a_res;
  logic [1023:0] a_img;
  logic          b_rdy, b_ena, b_trn, b_rv, b_busy, b_terr;
  logic [3:0]    b_res;
  logic [1023:0] b_img;

  tpu_host_feeder #(.TIMEOUT_CYCLES(TA)) dut_a (
    .clk(clk), .iRst_n(iRst_n),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(a_rdy), .frame_abort(frame_abort),
    .tpu_done(tpu_done), .tpu_num(tpu_num),
    .tpu_ena(a_ena), .tpu_rst_n(a_trn), .image(a_img),
    .result(a_res), .result_valid(a_rv),
    .busy(a_busy), .timeout_err(a_terr)
  );

  tpu_host_feeder #(.TIMEOUT_CYCLES(TB)) dut_b (
    .clk(clk), .iRst_n(iRst_n),
    .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(b_rdy), .frame_abort(frame_abort),
    .tpu_done(tpu_done), .tpu_num(tpu_num),
    .tpu_ena(b_ena), .tpu_rst_n(b_trn), .image(b_img),
    .result(b_res), .result_valid(b_rv),
    .busy(b_busy), .timeout_err(b_terr)
  );

  int            errs = 0;
  int            checks = 0;
  logic [1023:0] exp_img;
  logic [3:0]    exp_res [2];
  logic          exp_terr [2];

  task automatic chk(input string tag, input logic [1023:0] obs,
                     input logic [1023:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // {pix_ready, tpu_ena, tpu_rst_n, result_valid, busy, timeout_err, result}
  function automatic logic [9:0] ov(input int id);
    if (id == 0)
      return {a_rdy, a_ena, a_trn, a_rv, a_busy, a_terr, a_res};
    return {b_rdy, b_ena, b_trn, b_rv, b_busy, b_terr, b_res};
  endfunction

  function automatic logic [9:0] ev(input logic r, input logic e,
    input logic t, input logic v, input logic b, input logic x,
    input logic [3:0] n);
    return {r, e, t, v, b, x, n};
  endfunction

  function automatic logic [1023:0] img(input int id);
    return (id == 0) ? a_img : b_img;
  endfunction

  task automatic send_bytes(input int n, input bit rnd,
                            input logic [7:0] fix);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_abort = 1'b0;
      for (int id = 0; id < 2; id++) begin
        chk($sformatf("load%0d_b%0d", id, i), ov(id),
            ev(1, 0, 1, 0, 0, exp_terr[id], exp_res[id]));
        if (i == 0)
          chk($sformatf("img_load%0d", id), img(id), exp_img);
      end
      pix_valid = 1'b1;
      pix_data  = rnd ? 8'($urandom) : fix;
      exp_img[i*8 +: 8] = pix_data;
    end
  endtask

  task automatic send_frame(input bit rnd, input logic [7:0] fix);
    send_bytes(NB, rnd, fix);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic do_reset_check(input string tag);
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("%s%0d", tag, id), ov(id), ev(1, 0, 1, 0, 0, 0, 0));
      chk($sformatf("%s_img%0d", tag, id), img(id), '0);
      exp_res[id]  = '0;
      exp_terr[id] = 1'b0;
    end
    exp_img = '0;
  endtask

  // Entered at the negedge of the first TRST cycle.
  task automatic run_phase(input int done_at, input int abort_at,
                           input int rst_at, input logic [3:0] num);
    int e [2];
    int kind [2];
    int last;
    for (int id = 0; id < 2; id++) begin
      chk($sformatf("trst1_%0d", id), ov(id),
          ev(0, 1, 0, 0, 1, exp_terr[id], exp_res[id]));
      chk($sformatf("img_run%0d", id), img(id), exp_img);
    end
    @(negedge clk);
    for (int id = 0; id < 2; id++)
      chk($sformatf("trst2_%0d", id), ov(id),
          ev(0, 1, 0, 0, 1, exp_terr[id], exp_res[id]));
    for (int id = 0; id < 2; id++) begin
      e[id] = ((id == 0) ? TA : TB) - 1;
      kind[id] = 0;
      if (done_at >= 0 && done_at <= e[id]) begin
        e[id] = done_at;
        kind[id] = 1;
      end
      if (abort_at >= 0 && abort_at <= e[id]) begin
        e[id] = abort_at;
        kind[id] = 2;
      end
    end
    last = ((e[0] > e[1]) ? e[0] : e[1]) + 2;
    if (rst_at >= 0) last = rst_at;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      for (int id = 0; id < 2; id++) begin
        if (k <= e[id]) begin
          chk($sformatf("run%0d_k%0d", id, k), ov(id),
              ev(0, 1, 1, 0, 1, exp_terr[id], exp_res[id]));
        end else if (k == e[id] + 1) begin
          if (kind[id] == 1) begin
            exp_res[id]  = num;
            exp_terr[id] = 1'b0;
          end else if (kind[id] == 0) begin
            exp_terr[id] = 1'b1;
          end
          chk($sformatf("clr%0d_k%0d", id, k), ov(id),
              ev(0, 0, 1, kind[id] == 1, 0, exp_terr[id], exp_res[id]));
        end else begin
          chk($sformatf("idle%0d_k%0d", id, k), ov(id),
              ev(1, 0, 1, 0, 0, exp_terr[id], exp_res[id]));
        end
        if (k == 0 || k == last)
          chk($sformatf("img_hold%0d_k%0d", id, k), img(id), exp_img);
      end
      tpu_num     = num;
      tpu_done    = (k == done_at);
      frame_abort = (k == abort_at);
      if (k == rst_at) iRst_n = 1'b0;
    end
    if (rst_at >= 0) begin
      @(negedge clk);
      do_reset_check("midrst");
      iRst_n = 1'b1;
    end
    tpu_done    = 1'b0;
    frame_abort = 1'b0;
  endtask

  initial begin
    iRst_n      = 1'b0;
    pix_valid   = 1'b0;
    pix_data    = '0;
    frame_abort = 1'b0;
    tpu_done    = 1'b0;
    tpu_num     = '0;
    repeat (2) @(negedge clk);
    do_reset_check("reset");
    iRst_n = 1'b1;

    // all-0xA5 frame; A completes at RUN cycle 300, B times out first
    send_frame(1'b0, 8'hA5);
    chk("img_lo", {1016'd0, a_img[7:0]}, {1016'd0, 8'hA5});
    chk("img_hi", {1016'd0, a_img[1023:1016]}, {1016'd0, 8'hA5});
    run_phase(300, -1, -1, 4'd7);

    // partial frame, abort with a byte offered, then a full new frame
    send_bytes(60, 1'b1, 8'h00);
    @(negedge clk);
    frame_abort = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 8'hFF;
    send_frame(1'b1, 8'h00);
    run_phase($urandom_range(5, 40), -1, -1, 4'($urandom_range(0, 15)));

    // B times out again, then abort collides with done on A
    send_frame(1'b1, 8'h00);
    run_phase(-1, 100, -1, 4'd9);
    send_frame(1'b1, 8'h00);
    run_phase(20, 20, -1, 4'd3);

    // random successful runs
    for (int r = 0; r < 2; r++) begin
      send_frame(1'b1, 8'h00);
      run_phase($urandom_range(0, 62), -1, -1, 4'($urandom_range(0, 15)));
    end

    // reset mid-run, then a clean frame
    send_frame(1'b1, 8'h00);
    run_phase(-1, -1, 10, 4'd5);
    send_frame(1'b1, 8'h00);
    run_phase($urandom_range(1, 50), -1, -1, 4'd2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/tpu_host_feeder.md
Name: tpu_host_feeder

Overview:
- Initiator side of the inference control handshake: collects a 32x32 binary image from a byte stream and holds it stable as the 1024-bit image bus.
- Drives the inference controller's enable and reset lines, waits for its done flag, then latches the 4-bit class result.
- Sits between the pixel source (UART receive or drawing-pad logic) and the inference controller. Its result feeds the display.

Parameters:
- IMG_BYTES, 128: bytes per frame; 8 pixels per byte, 1024 pixels total.
- RST_CYCLES, 2: cycles the controller reset is held low, with enable high.
- TIMEOUT_CYCLES, 1048576: maximum RUN cycles before the run is abandoned.

Ports:
- clk  in  1  system clock
- iRst_n  in  1  synchronous active-low reset
- pix_valid  in  1  pix_data holds a valid byte
- pix_data  in  8  8 pixels; bit 7 is the highest pixel index within the byte
- pix_ready  out  1  byte accepted when pix_valid && pix_ready
- frame_abort  in  1  discards the partial frame or cancels a run in progress
- tpu_done  in  1  done flag from the inference controller
- tpu_num  in  4  class index from the controller, valid while tpu_done=1
- tpu_ena  out  1  controller enable
- tpu_rst_n  out  1  controller synchronous reset, active low
- image  out  1024  assembled frame presented to the controller
- result  out  4  last recognised digit
- result_valid  out  1  one-cycle pulse when result updates
- busy  out  1  high in TRST and RUN
- timeout_err  out  1  sticky flag: last run timed out

Behaviour:
- All logic is on posedge clk. Reset is synchronous and active-low (iRst_n=0).
- Reset values: state=LOAD, byte_cnt=0, image=0, pix_ready=1, tpu_ena=0, tpu_rst_n=1, result=0, result_valid=0, busy=0, timeout_err=0, run timer=0.
- States: LOAD, TRST, RUN, CLR.
- LOAD:
  - pix_ready=1.
  - Each accepted byte is written as image[byte_cnt*8 +: 8] <= pix_data, then byte_cnt increments.
  - When the byte with byte_cnt=IMG_BYTES-1 is accepted: byte_cnt<=0 and state<=TRST. Registered in the same edge: pix_ready<=0, busy<=1, tpu_ena<=1, tpu_rst_n<=0.
- TRST:
  - tpu_ena=1 and tpu_rst_n=0 for exactly RST_CYCLES cycles, then tpu_rst_n<=1 and state<=RUN.
  - Run timer is cleared on entry to RUN.
- RUN:
  - The timer increments every cycle.
  - If tpu_done=1: result<=tpu_num, result_valid<=1 for one cycle, timeout_err<=0, state<=CLR.
  - Else if timer==TIMEOUT_CYCLES-1: timeout_err<=1, state<=CLR, result unchanged.
- CLR:
  - tpu_ena=0 for one cycle; this clears the controller's done flag.
  - tpu_rst_n=1, busy<=0, pix_ready<=1, state<=LOAD.
- Latency: from the last byte accepted to the first tpu_ena=1 cycle is 1 cycle. From tpu_done=1 sampled to result_valid=1 is 1 cycle.
- Boundary conditions:
  - image is never written outside LOAD, so it is stable for the whole of TRST and RUN.
  - tpu_done is ignored outside RUN.
  - frame_abort in LOAD: byte_cnt<=0. image bits are not cleared. A byte offered in the same cycle is dropped.
  - frame_abort in TRST or RUN: go to CLR with no result_valid and timeout_err unchanged. Abort has priority over a simultaneous tpu_done or timeout.
  - Reset mid-run: all outputs return to their reset values on the next edge. tpu_ena=0 releases the controller.
  - result holds its value until the next successful run.

Decomposition:
- Shared package holds:
  - state encoding constants: LOAD=2'd0, TRST=2'd1, RUN=2'd2, CLR=2'd3;
  - IMG_BITS=1024;
  - the class-index width of 4.
- No sub-module is required; the byte shifter, counters and FSM fit in one module of about 150-200 lines.

Test Plan:
- Reset, then send 128 bytes of 0xA5 back-to-back -> image[7:0]=8'hA5 and image[1023:1016]=8'hA5; tpu_ena rises 1 cycle after the last accept; tpu_rst_n low for exactly 2 cycles; pix_ready=0 and busy=1 throughout.
- In RUN, a model raises tpu_done with tpu_num=4'd7 after 300 cycles -> result=7, result_valid high for exactly 1 cycle, next cycle tpu_ena=0, then pix_ready=1.
- Send 60 bytes, assert frame_abort, then send 128 bytes -> the run starts only after the 128th new byte, not after the 68th.
- Set TIMEOUT_CYCLES=64 with the model never raising done -> timeout_err=1 at RUN cycle 64; no result_valid; result keeps its previous value; returns to LOAD. A following successful run clears timeout_err.
- Assert frame_abort and tpu_done in the same RUN cycle -> no result_valid, result unchanged, state goes CLR then LOAD.
- Drive iRst_n=0 during RUN -> next edge tpu_ena=0, busy=0, pix_ready=1, byte_cnt=0, image=0.
